// File: rtl/norm_pkg.sv
// Shared constants and FSM state encoding for the leading-zero normalizer.
// Optional abort input is enabled by defining NORM_ABORT_EN.
package norm_pkg;

    localparam int WIDTH      = 16;
    localparam int CNT_W      = 5;
    localparam int ZERO_SHAMT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } norm_state_e;

endpackage

// File: rtl/norm_shreg.sv
// Datapath register for the normalizer: parallel load, shift-left by one
// with zero fill, or hold. Load wins when both controls are asserted.
module norm_shreg #(
    parameter int W = norm_pkg::WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld_i,
    input  logic         shl_en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o,
    output logic         msb_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (ld_i) begin
            q_d = d_i;
        end else if (shl_en_i) begin
            q_d = {q_q[W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o   = q_q;
    assign msb_o = q_q[W-1];

endmodule

// File: rtl/lead_norm_ctrl.sv
// Leading-zero normalizer: shifts the operand left one bit per cycle until
// its MSB is set, counting shifts. Define NORM_ABORT_EN to add the abort input.
module lead_norm_ctrl #(
    parameter int WIDTH = norm_pkg::WIDTH,
    parameter int CNT_W = norm_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
`ifdef NORM_ABORT_EN
    input  logic             abort,
`endif
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] shamt,
    output logic             zero
);

    import norm_pkg::*;

    localparam logic [CNT_W-1:0] SHAMT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] SHAMT_ZERO = CNT_W'(ZERO_SHAMT);

    norm_state_e      state_q, state_d;
    logic [CNT_W-1:0] shamt_q, shamt_d;
    logic             zero_q, zero_d;
    logic             ld;
    logic             shl_en;
    logic             msb;
    logic             abort_hit;

`ifdef NORM_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    norm_shreg #(.W(WIDTH)) u_shreg (
        .clk      (clk),
        .rst      (rst),
        .ld_i     (ld),
        .shl_en_i (shl_en),
        .d_i      (din),
        .q_o      (dout),
        .msb_o    (msb)
    );

    always_comb begin
        state_d = state_q;
        shamt_d = shamt_q;
        zero_d  = zero_q;
        ld      = 1'b0;
        shl_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ld      = 1'b1;
                    shamt_d = '0;
                    zero_d  = (din == '0);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Abort leaves the partial result visible in dout/shamt.
                if (abort_hit) begin
                    state_d = IDLE;
                end else if (zero_q) begin
                    shamt_d = SHAMT_ZERO;
                    state_d = DONE;
                end else if (msb) begin
                    state_d = DONE;
                end else begin
                    shl_en  = 1'b1;
                    shamt_d = shamt_q + SHAMT_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shamt_q <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shamt_q <= shamt_d;
            zero_q  <= zero_d;
        end
    end

    assign busy  = (state_q == SHIFT);
    assign done  = (state_q == DONE);
    assign shamt = shamt_q;
    assign zero  = zero_q;

endmodule

// File: tb/tb_lead_norm_ctrl.sv
// Directed bench for lead_norm_ctrl; abort steps compile in with NORM_ABORT_EN.
module tb_lead_norm_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] din;
    logic        busy;
    logic        done;
    logic [15:0] dout;
    logic [4:0]  shamt;
    logic        zero;
`ifdef NORM_ABORT_EN
    logic        abort;
`endif

    int checks   = 0;
    int failures = 0;

    lead_norm_ctrl dut (
        .clk   (clk),
        .rst   (rst),
`ifdef NORM_ABORT_EN
        .abort (abort),
`endif
        .start (start),
        .din   (din),
        .busy  (busy),
        .done  (done),
        .dout  (dout),
        .shamt (shamt),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start one operation and follow it to completion; junk=1 keeps start
    // high with din=0xFFFF throughout SHIFT, which must be ignored.
    task automatic run_op(input string tag, input logic [15:0] d, input int exp_cycles,
                          input logic [4:0] exp_shamt, input logic [15:0] exp_dout,
                          input logic exp_zero, input bit junk);
        int n;
        int nbusy;
        start = 1'b1;
        din   = d;
        step();
        if (junk) begin
            din = 16'hFFFF;
        end else begin
            start = 1'b0;
            din   = 16'($urandom_range(0, 16'hFFFF));
        end
        n     = 1;
        nbusy = 0;
        while (done !== 1'b1 && n < 40) begin
            if (busy === 1'b1) nbusy++;
            step();
            n++;
        end
        start = 1'b0;
        check({tag, "_latency"}, n, exp_cycles);
        check({tag, "_busy_cycles"}, nbusy, exp_cycles - 1);
        check({tag, "_busy_in_done"}, busy, 1'b0);
        check({tag, "_shamt"}, shamt, exp_shamt);
        check({tag, "_dout"}, dout, exp_dout);
        check({tag, "_zero"}, zero, exp_zero);
        step();
        check({tag, "_done_one_cycle"}, done, 1'b0);
        for (int i = 0; i < 3; i++) begin
            din = 16'($urandom_range(0, 16'hFFFF));
            step();
        end
        check({tag, "_hold_idle"}, {busy, done}, 2'b00);
        check({tag, "_hold_shamt"}, shamt, exp_shamt);
        check({tag, "_hold_dout"}, dout, exp_dout);
        check({tag, "_hold_zero"}, zero, exp_zero);
    endtask

    initial begin
        int seen_done;
        rst   = 1'b1;
        start = 1'b0;
        din   = 16'h0000;
`ifdef NORM_ABORT_EN
        abort = 1'b0;
`endif
        #1;
        check("reset_outputs", {busy, done, dout, shamt, zero}, 24'h0);
        step();
        step();
        rst = 1'b0;

        run_op("msb_set",   16'h8000, 2,  5'd0,  16'h8000, 1'b0, 1'b0);
        run_op("one",       16'h0001, 17, 5'd15, 16'h8000, 1'b0, 1'b0);
        run_op("f3_junk",   16'h00F3, 10, 5'd8,  16'hF300, 1'b0, 1'b1);
        run_op("zero_op",   16'h0000, 2,  5'd16, 16'h0000, 1'b1, 1'b0);
        run_op("x1234",     16'h1234, 5,  5'd3,  16'h91A0, 1'b0, 1'b0);
        run_op("all_ones",  16'hFFFF, 2,  5'd0,  16'hFFFF, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a SHIFT sequence.
        start = 1'b1;
        din   = 16'h0004;
        step();
        start = 1'b0;
        step();
        step();
        check("pre_rst_busy", busy, 1'b1);
        check("pre_rst_shamt", shamt, 5'd2);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_outputs", {busy, done, dout, shamt, zero}, 24'h0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        seen_done = 0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) seen_done++;
            step();
        end
        check("no_done_after_rst", seen_done, 0);
        run_op("post_rst", 16'h4000, 3, 5'd1, 16'h8000, 1'b0, 1'b0);

`ifdef NORM_ABORT_EN
        // Abort in the third SHIFT cycle keeps the partial result.
        start = 1'b1;
        din   = 16'h0010;
        step();
        start = 1'b0;
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_idle", {busy, done}, 2'b00);
        check("abort_shamt", shamt, 5'd2);
        check("abort_dout", dout, 16'h0040);
        seen_done = 0;
        for (int i = 0; i < 15; i++) begin
            if (done === 1'b1) seen_done++;
            step();
        end
        check("abort_no_done", seen_done, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_ignored_idle", {busy, done, shamt}, {2'b00, 5'd2});
        run_op("after_abort", 16'h0010, 13, 5'd11, 16'h8000, 1'b0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lead_norm_ctrl.md
LEAD_NORM_CTRL -- requirements
Module: lead_norm_ctrl

Interface
REQ-001 Parameter WIDTH, default 16: data width; fixed at 16.
REQ-002 Parameter CNT_W, default 5: shift-count width; holds 0..16.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to normalize din; sampled on a clk edge while in IDLE.
REQ-006 din  input  16  operand, sampled on the edge that accepts start.
REQ-007 busy  output  1  high while in SHIFT.
REQ-008 done  output  1  single-cycle pulse, high only in DONE.
REQ-009 dout  output  16  normalized value; direct copy of the internal shift register.
REQ-010 shamt  output  5  number of left shifts applied; 16 for a zero operand.
REQ-011 zero  output  1  high when the last accepted operand was 0.

Function
REQ-012 The internal 16-bit register shall support parallel load (ld), shift-left by 1 with 0 fill (shl_en), and hold; ld has priority over shl_en.
REQ-013 The FSM shall have the states IDLE, SHIFT and DONE.
REQ-014 IDLE with start=1: at the edge, register <= din, shamt <= 0, zero <= (din==0), state -> SHIFT.
REQ-015 IDLE with start=0: hold all registers.
REQ-016 SHIFT with zero=1: at the edge, shamt <= 16, state -> DONE; the register holds 0.
REQ-017 SHIFT with register[15]=1: state -> DONE; register and shamt hold.
REQ-018 SHIFT with register[15]=0 and zero=0: register shifts left by 1 and shamt increments by 1; state stays SHIFT.
REQ-019 DONE: done=1 for exactly one cycle, then state -> IDLE unconditionally.
REQ-020 Latency: for an operand with k leading zeros (k=0..15), done is high in the (k+2)th cycle after the accepting edge; for a zero operand, in the 2nd cycle.
REQ-021 start shall be ignored in SHIFT and DONE; no queuing.
REQ-022 din shall be don't-care except on the accepting edge.
REQ-023 dout, shamt and zero shall hold their values from DONE until the next accepted start.
REQ-024 shamt shall never exceed 16 and shall never wrap.
REQ-025 After a nonzero operand completes, dout[15]=1 and dout = din << shamt (16-bit, truncated).

Reset
REQ-026 rst=1 shall force, without waiting for clk: state=IDLE, register=0x0000, shamt=0, zero=0, busy=0, done=0.
REQ-027 rst asserted mid-operation shall abandon the operation; no done pulse shall follow.
REQ-028 After rst deasserts, the first start shall be accepted on the first rising edge with start=1.

Configuration
REQ-029 Macro NORM_ABORT_EN defined: an input port abort (1 bit) shall exist; abort=1 in SHIFT returns the block to IDLE at the next edge with no done pulse, leaving register, shamt and zero at their current values; abort is ignored in IDLE and DONE.
REQ-030 Macro NORM_ABORT_EN undefined: the abort port and its logic shall be absent; behaviour is REQ-012..REQ-025 unchanged.

Structure
REQ-031 A shared package norm_pkg shall hold the state encoding constants (IDLE, SHIFT, DONE), WIDTH=16, CNT_W=5 and ZERO_SHAMT=16.
REQ-032 A single sub-module norm_shreg (16-bit register with ld/shl_en, async reset, MSB_out) shall implement the datapath register; the FSM, counter and flags stay in lead_norm_ctrl.

Verification
REQ-033 din=0x8000, start pulse -> done in 2nd cycle, shamt=0, dout=0x8000, zero=0.
REQ-034 din=0x0001 -> busy for 16 cycles, done in 17th cycle, shamt=15, dout=0x8000.
REQ-035 din=0x00F3 -> done in 10th cycle, shamt=8, dout=0xF300; start=1 with din=0xFFFF held throughout SHIFT is ignored.
REQ-036 din=0x0000 -> done in 2nd cycle, shamt=16, zero=1, dout=0x0000.
REQ-037 din=0x0004; rst pulsed mid-SHIFT between clock edges -> outputs go to reset values immediately; no done; a following start with din=0x4000 yields shamt=1, dout=0x8000.
REQ-038 NORM_ABORT_EN defined, din=0x0010, abort pulsed in the 3rd SHIFT cycle -> IDLE with no done, shamt=2, dout=0x0040; the next start is accepted normally.
